mod_inp_sched: RTL and testbench
================================

// Module: mod_inp_sched
// PURPOSE
//  Input-side sequencer for the AES core: accepts 32-bit master writes, steers addr=0 words to regCTRL
//  and packs addr=1 words into one 128-bit plaintext block for the encrypter (addRK stage).
//  Owns the word counter, block-issue handshake and master back-pressure.
//  Sits between the master bus and regCTRL / encrypter input.
// PARAMETERS
//  WORD_W   32  bus word width (bits)
//  N_WORDS  4   words per plaintext block (block = WORD_W*N_WORDS = 128 bits)
//  NFLAGS   32  regCTRL flag width (== WORD_W)
// PORTS
//  clk         in   1        single clock, all logic rising-edge
//  rst         in   1        synchronous, active-high reset
//  wr_en       in   1        master write strobe
//  addr        in   1        0 = regCTRL flags, 1 = plaintext data
//  wdata       in   WORD_W   master write data
//  wr_ready    out  1        write accepted this cycle when wr_en & wr_ready
//  ctrl_we     out  1        one-cycle pulse: ctrl_flags updated
//  ctrl_flags  out  NFLAGS   last accepted flags word (held)
//  blk_valid   out  1        plaintext block available
//  blk_data    out  128      packed plaintext, [N_WORDS-1:0][3:0][7:0]
//  blk_ready   in   1        encrypter accepts block
//  fill_cnt    out  2        data words collected in current block
//  abort       in   1        (INP_SCHED_ABORT_EN only) discard partial block
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=S_FILL, fill_cnt=0, wr_ready=1 (combinational from state),
//   ctrl_we=0, ctrl_flags=0, blk_valid=0, blk_data=0.
//  FSM: S_FILL -> S_ISSUE when 4th data word accepted; S_ISSUE -> S_FILL on blk_valid & blk_ready.
//  wr_ready = (state==S_FILL). Writes with wr_en & !wr_ready are ignored; master must hold them.
//  Accept = wr_en & wr_ready.
//  addr=0 accept at cycle t: ctrl_flags<=wdata, ctrl_we=1 during t+1 only; fill_cnt/blk_data untouched
//   (a flags write mid-block is legal and does not disturb packing).
//  addr=1 accept: blk_data[fill_cnt][i] <= wdata[8*i +: 8], i=0..3; fill_cnt<=fill_cnt+1 (mod 4).
//   On the word with fill_cnt==3: fill_cnt wraps to 0, state<=S_ISSUE, blk_valid=1 from t+1.
//  S_ISSUE: blk_valid=1, blk_data stable until transfer cycle; transfer -> blk_valid=0 and wr_ready=1
//   next cycle. Min block period: 4 write cycles + 1 transfer cycle.
//  blk_ready while blk_valid=0 is ignored.
//  rst mid-block or in S_ISSUE: partial/pending block dropped, all outputs to reset values.
// CONFIGURATION
//  `INP_SCHED_ABORT_EN defined: abort port present. abort=1 at an edge: fill_cnt<=0, state<=S_FILL,
//   blk_valid<=0, ctrl_flags kept. abort beats a simultaneous write (write dropped) and a
//   simultaneous blk_ready (no transfer counted).
//  Undefined: no abort port; partial blocks are cleared only by rst.
// STRUCTURE
//  aes_pkg: WORD_W/N_WORDS/NFLAGS constants, blk_t = logic [N_WORDS-1:0][3:0][7:0],
//   state enum inp_sched_st_e {S_FILL, S_ISSUE}.
//  One sub-module: mod_blk_packer (word-indexed byte-lane write into blk_t with clear); FSM, counter
//   and ctrl path stay in the top module.
// TESTING
//  1 rst, then 4 addr=1 writes 0x03020100,0x07060504,0x0B0A0908,0x0F0E0D0C, blk_ready=1 ->
//    blk_valid 1 cycle after 4th write, blk_data bytes 0x00..0x0F in order, wr_ready low that cycle.
//  2 addr=0 write 0xDEADBEEF -> ctrl_we pulses one cycle, ctrl_flags=0xDEADBEEF, fill_cnt unchanged.
//  3 full block with blk_ready=0 for 5 cycles, wr_en held with addr=1 -> blk_valid/blk_data stable,
//    wr_ready=0, held write accepted only after transfer; fill_cnt then 1.
//  4 2 data words, flags write, 2 data words -> one block, data = the 4 data words, flags updated.
//  5 rst asserted after 3 data words -> fill_cnt=0, blk_valid=0; next 4 words form a fresh block.
//  6 (`INP_SCHED_ABORT_EN) abort with 2 words pending + simultaneous write -> fill_cnt=0, write dropped.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES input-side types: bus/block widths,
// packed plaintext block type and the input sequencer state enum.
package aes_pkg;
  localparam int WORD_W  = 32;
  localparam int N_WORDS = 4;
  localparam int NFLAGS  = 32;
  localparam int BLK_W   = WORD_W * N_WORDS;
  localparam int CNT_W   = 2;

  typedef logic [N_WORDS-1:0][3:0][7:0] blk_t;

  typedef enum logic {
    S_FILL,
    S_ISSUE
  } inp_sched_st_e;
endpackage

// File: rtl/mod_blk_packer.sv
// Plaintext block register: writes one 32-bit word into word slot idx
// byte-lane by byte-lane. Ports: clk, clr (sync clear), we, idx, wdata, blk.
module mod_blk_packer
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [CNT_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output blk_t              blk
);

  always_ff @(posedge clk) begin
    if (clr) begin
      blk <= '0;
    end else if (we) begin
      for (int i = 0; i < 4; i++) begin
        blk[idx][i] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mod_inp_sched.sv
// AES input sequencer: routes addr=0 writes to the ctrl flags and packs
// addr=1 writes into 128-bit blocks handed to the encrypter with a
// valid/ready handshake; wr_ready back-pressures the master while a block
// is pending. Ports: clk, rst, wr_en/addr/wdata/wr_ready (master),
// ctrl_we/ctrl_flags, blk_valid/blk_data/blk_ready, fill_cnt.
// Optional: define INP_SCHED_ABORT_EN to add the abort input.
module mod_inp_sched
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              wr_ready,
  output logic              ctrl_we,
  output logic [NFLAGS-1:0] ctrl_flags,
  output logic              blk_valid,
  output blk_t              blk_data,
  input  logic              blk_ready,
  output logic [CNT_W-1:0]  fill_cnt
`ifdef INP_SCHED_ABORT_EN
  ,
  input  logic              abort
`endif
);

  inp_sched_st_e state, state_n;

  logic kill;
  logic acc;
  logic acc_d;
  logic acc_c;
  logic last;
  logic xfer;

`ifdef INP_SCHED_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign wr_ready  = (state == S_FILL);
  assign blk_valid = (state == S_ISSUE);

  // abort wins over any same-cycle write or transfer
  assign acc   = wr_en & wr_ready & ~kill;
  assign acc_d = acc & addr;
  assign acc_c = acc & ~addr;
  assign last  = (fill_cnt == 2'd3);
  assign xfer  = blk_valid & blk_ready & ~kill;

  always_comb begin
    state_n = state;
    unique case (1'b1)
      kill:         state_n = S_FILL;
      acc_d & last: state_n = S_ISSUE;
      xfer:         state_n = S_FILL;
      default:      state_n = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FILL;
      fill_cnt   <= '0;
      ctrl_we    <= 1'b0;
      ctrl_flags <= '0;
    end else begin
      state   <= state_n;
      ctrl_we <= acc_c;
      if (acc_c) begin
        ctrl_flags <= wdata;
      end
      if (kill) begin
        fill_cnt <= '0;
      end else if (acc_d) begin
        fill_cnt <= fill_cnt + 2'd1;
      end
    end
  end

  mod_blk_packer u_pack (
    .clk   (clk),
    .clr   (rst),
    .we    (acc_d),
    .idx   (fill_cnt),
    .wdata (wdata),
    .blk   (blk_data)
  );

endmodule

// File: tb/tb_mod_inp_sched.sv
// Scoreboard bench for mod_inp_sched: word-queue reference model,
// directed scenarios followed by randomized traffic.
module tb_mod_inp_sched;
  import aes_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              addr;
  logic [WORD_W-1:0] wdata;
  logic              wr_ready;
  logic              ctrl_we;
  logic [NFLAGS-1:0] ctrl_flags;
  logic              blk_valid;
  blk_t              blk_data;
  logic              blk_ready;
  logic [CNT_W-1:0]  fill_cnt;
  logic              kill_m;
`ifdef INP_SCHED_ABORT_EN
  logic              abort;
  assign kill_m = abort;
`else
  assign kill_m = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_on = 0;

  logic [31:0]  cur[$];
  logic [127:0] exp_blk[$];
  bit           pend;
  bit           m_we;
  logic [31:0]  m_flags;

  always #5 clk = ~clk;

  mod_inp_sched dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .addr       (addr),
    .wdata      (wdata),
    .wr_ready   (wr_ready),
    .ctrl_we    (ctrl_we),
    .ctrl_flags (ctrl_flags),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .blk_ready  (blk_ready),
    .fill_cnt   (fill_cnt)
`ifdef INP_SCHED_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: collect words, emit a block per 4 data words
  initial begin
    pend    = 0;
    m_we    = 0;
    m_flags = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        cur.delete();
        exp_blk.delete();
        pend    = 0;
        m_we    = 0;
        m_flags = '0;
      end else if (kill_m) begin
        cur.delete();
        exp_blk.delete();
        pend = 0;
        m_we = 0;
      end else begin
        m_we = 0;
        if (pend) begin
          if (blk_ready) begin
            pend = 0;
            void'(exp_blk.pop_front());
          end
        end else if (wr_en) begin
          if (!addr) begin
            m_we    = 1;
            m_flags = wdata;
          end else begin
            cur.push_back(wdata);
            if (cur.size() == 4) begin
              exp_blk.push_back(
                {cur[3], cur[2], cur[1], cur[0]});
              cur.delete();
              pend = 1;
            end
          end
        end
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("wr_ready", 128'(wr_ready), 128'(!pend));
        chk("blk_valid", 128'(blk_valid), 128'(pend));
        chk("fill_cnt", 128'(fill_cnt), 128'(cur.size()));
        chk("ctrl_we", 128'(ctrl_we), 128'(m_we));
        chk("ctrl_flags", 128'(ctrl_flags), 128'(m_flags));
        if (blk_valid) begin
          if (exp_blk.size() == 0)
            chk("blk_unexpected", 128'(1), 128'(0));
          else
            chk("blk_data", blk_data, exp_blk[0]);
        end
      end
    end
  end

  task automatic wr(input logic a, input logic [31:0] d);
    int  n    = 0;
    bit  done = 0;
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    while (!done) begin
      @(negedge clk);
      done = wr_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        chk("wr_timeout", 128'(0), 128'(1));
        done = 1;
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    addr      = 1'b0;
    wdata     = '0;
    blk_ready = 1'b0;
`ifdef INP_SCHED_ABORT_EN
    abort     = 1'b0;
`endif
    @(posedge clk);
    mon_on = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_blk_data", blk_data, 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: byte-ordered block
    blk_ready = 1'b1;
    wr(1, 32'h03020100);
    wr(1, 32'h07060504);
    wr(1, 32'h0B0A0908);
    wr(1, 32'h0F0E0D0C);
    @(negedge clk);
    chk("t1_blk",
        blk_data, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_wr_ready", 128'(wr_ready), 128'(0));
    cyc(2);

    // 2: flags write
    wr(0, 32'hDEADBEEF);
    cyc(2);

    // 3: back-pressure with a held write
    blk_ready = 1'b0;
    wr(1, 32'h11111111);
    wr(1, 32'h22222222);
    wr(1, 32'h33333333);
    wr(1, 32'h44444444);
    fork
      wr(1, 32'h55555555);
      begin
        cyc(5);
        blk_ready = 1'b1;
      end
    join
    @(negedge clk);
    chk("t3_fill", 128'(fill_cnt), 128'(1));
    cyc(1);

    // 5 (first, realigning): reset mid-block
    wr(1, 32'hA0A0A0A0);
    wr(1, 32'hA1A1A1A1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;

    // 4: flags write in the middle of a block
    wr(1, 32'hC0000000);
    wr(1, 32'hC1111111);
    wr(0, 32'h12345678);
    wr(1, 32'hC2222222);
    wr(1, 32'hC3333333);
    cyc(2);

    // 5: three words then reset, then a fresh block
    wr(1, 32'h01010101);
    wr(1, 32'h02020202);
    wr(1, 32'h03030303);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_fill", 128'(fill_cnt), 128'(0));
    chk("t5_valid", 128'(blk_valid), 128'(0));
    cyc(1);
    wr(1, 32'hB0B0B0B0);
    wr(1, 32'hB1B1B1B1);
    wr(1, 32'hB2B2B2B2);
    wr(1, 32'hB3B3B3B3);
    cyc(2);

`ifdef INP_SCHED_ABORT_EN
    // 6: abort with a simultaneous write
    wr(1, 32'hE0E0E0E0);
    wr(1, 32'hE1E1E1E1);
    wr_en = 1'b1;
    addr  = 1'b1;
    wdata = 32'hE2E2E2E2;
    abort = 1'b1;
    cyc(1);
    wr_en = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("t6_fill", 128'(fill_cnt), 128'(0));
    cyc(1);
`endif

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      wr_en     = 1'($urandom % 2);
      addr      = 1'(($urandom % 4) != 0);
      wdata     = $urandom;
      blk_ready = 1'(($urandom % 3) != 0);
      rst       = 1'(($urandom % 80) == 0);
`ifdef INP_SCHED_ABORT_EN
      abort     = 1'(($urandom % 30) == 0);
`endif
      cyc(1);
    end
    wr_en     = 1'b0;
    rst       = 1'b0;
    blk_ready = 1'b1;
`ifdef INP_SCHED_ABORT_EN
    abort     = 1'b0;
`endif
    cyc(3);
    chk("drain", 128'(exp_blk.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
